// File: rtl/contorl_unit_001.sv
// Microprogrammed control unit: an 8-bit control address register walks a fixed
// control ROM; CBR is the registered control word for the current address.
module contorl_unit_001 (
  input  logic        CLK,
  input  logic        RST,
  input  logic        zflag,
  input  logic [7:0]  IR,
  output logic [31:0] CBR
);

  localparam logic [13:0] B_PC_MAR  = 14'h0001;
  localparam logic [13:0] B_MEM_RD  = 14'h0002;
  localparam logic [13:0] B_MEM_MBR = 14'h0004;
  localparam logic [13:0] B_PC_INC  = 14'h0008;
  localparam logic [13:0] B_MBR_IR  = 14'h0010;
  localparam logic [13:0] B_IRA_MAR = 14'h0020;
  localparam logic [13:0] B_MBR_ACC = 14'h0040;
  localparam logic [13:0] B_ACC_MBR = 14'h0080;
  localparam logic [13:0] B_MEM_WR  = 14'h0100;
  localparam logic [13:0] B_ALU_ADD = 14'h0200;
  localparam logic [13:0] B_ALU_SUB = 14'h0400;
  localparam logic [13:0] B_ALU_ACC = 14'h0800;
  localparam logic [13:0] B_IRA_PC  = 14'h1000;
  localparam logic [13:0] B_HALT    = 14'h2000;

  logic [7:0]  car_q;
  logic [7:0]  car_d;
  logic [31:0] cbr_q;
  logic [31:0] cbr_d;

  function automatic logic [13:0] rom_bits(input logic [7:0] addr);
    logic [13:0] bits;
    case (addr)
      8'h00:   bits = B_PC_MAR;
      8'h01:   bits = B_MEM_RD | B_MEM_MBR | B_PC_INC;
      8'h02:   bits = B_MBR_IR;
      8'h10:   bits = B_IRA_MAR;
      8'h11:   bits = B_MEM_RD | B_MEM_MBR;
      8'h12:   bits = B_MBR_ACC;
      8'h20:   bits = B_IRA_MAR;
      8'h21:   bits = B_ACC_MBR;
      8'h22:   bits = B_MEM_WR;
      8'h30:   bits = B_IRA_MAR;
      8'h31:   bits = B_MEM_RD | B_MEM_MBR;
      8'h32:   bits = B_ALU_ADD | B_ALU_ACC;
      8'h40:   bits = B_IRA_MAR;
      8'h41:   bits = B_MEM_RD | B_MEM_MBR;
      8'h42:   bits = B_ALU_SUB | B_ALU_ACC;
      8'h50:   bits = 14'h0000;
      8'h51:   bits = B_IRA_PC;
      8'h60:   bits = B_IRA_PC;
      8'h70:   bits = B_HALT;
      default: bits = 14'h0000;
    endcase
    return bits;
  endfunction

  // Unknown opcodes fall back to fetch, so they behave as a NOP.
  function automatic logic [7:0] dispatch(input logic [7:0] op);
    logic [7:0] tgt;
    case (op)
      8'h01:   tgt = 8'h10;
      8'h02:   tgt = 8'h20;
      8'h03:   tgt = 8'h30;
      8'h04:   tgt = 8'h40;
      8'h05:   tgt = 8'h50;
      8'h06:   tgt = 8'h60;
      8'h07:   tgt = 8'h70;
      default: tgt = 8'h00;
    endcase
    return tgt;
  endfunction

  // IR and zflag are consulted only at their single decision microword each.
  function automatic logic [7:0] next_addr(input logic [7:0] addr,
                                           input logic [7:0] op,
                                           input logic       zf);
    logic [7:0] nxt;
    case (addr)
      8'h00:   nxt = 8'h01;
      8'h01:   nxt = 8'h02;
      8'h02:   nxt = dispatch(op);
      8'h10:   nxt = 8'h11;
      8'h11:   nxt = 8'h12;
      8'h20:   nxt = 8'h21;
      8'h21:   nxt = 8'h22;
      8'h30:   nxt = 8'h31;
      8'h31:   nxt = 8'h32;
      8'h40:   nxt = 8'h41;
      8'h41:   nxt = 8'h42;
      8'h50:   nxt = zf ? 8'h51 : 8'h00;
      8'h70:   nxt = 8'h70;
      default: nxt = 8'h00;
    endcase
    return nxt;
  endfunction

  // Next control address and the control word it selects.
  always_comb begin
    car_d = next_addr(car_q, IR, zflag);
    cbr_d = {car_d, 10'd0, rom_bits(car_d)};
  end

  // CBR is loaded with the word of the new address on the same edge as CAR.
  always_ff @(posedge CLK) begin
    if (RST) begin
      car_q <= 8'h00;
      cbr_q <= 32'h0000_0001;
    end else begin
      car_q <= car_d;
      cbr_q <= cbr_d;
    end
  end

  assign CBR = cbr_q;

endmodule

// File: tb/tb_contorl_unit_001.sv
// Randomized bench for contorl_unit_001: expected CBR sequences are built per
// instruction from the routine tables and compared cycle by cycle.
module tb_contorl_unit_001;

  logic        CLK;
  logic        RST;
  logic        zflag;
  logic [7:0]  IR;
  logic [31:0] CBR;

  int checks;
  int failures;

  logic [31:0] exp_q[$];

  localparam logic [13:0] B_PC_MAR  = 14'h0001;
  localparam logic [13:0] B_MEM_RD  = 14'h0002;
  localparam logic [13:0] B_MEM_MBR = 14'h0004;
  localparam logic [13:0] B_PC_INC  = 14'h0008;
  localparam logic [13:0] B_MBR_IR  = 14'h0010;
  localparam logic [13:0] B_IRA_MAR = 14'h0020;
  localparam logic [13:0] B_MBR_ACC = 14'h0040;
  localparam logic [13:0] B_ACC_MBR = 14'h0080;
  localparam logic [13:0] B_MEM_WR  = 14'h0100;
  localparam logic [13:0] B_ALU_ADD = 14'h0200;
  localparam logic [13:0] B_ALU_SUB = 14'h0400;
  localparam logic [13:0] B_ALU_ACC = 14'h0800;
  localparam logic [13:0] B_IRA_PC  = 14'h1000;
  localparam logic [13:0] B_HALT    = 14'h2000;

  contorl_unit_001 dut (
    .CLK   (CLK),
    .RST   (RST),
    .zflag (zflag),
    .IR    (IR),
    .CBR   (CBR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] w(input logic [7:0] a, input logic [13:0] b);
    return {a, 10'd0, b};
  endfunction

  // Expected words from the fetch word up to (not including) the next fetch word.
  task automatic build(input logic [7:0] op, input logic z, input int hold);
    exp_q.delete();
    exp_q.push_back(w(8'h00, B_PC_MAR));
    exp_q.push_back(w(8'h01, B_MEM_RD | B_MEM_MBR | B_PC_INC));
    exp_q.push_back(w(8'h02, B_MBR_IR));
    case (op)
      8'h01: begin
        exp_q.push_back(w(8'h10, B_IRA_MAR));
        exp_q.push_back(w(8'h11, B_MEM_RD | B_MEM_MBR));
        exp_q.push_back(w(8'h12, B_MBR_ACC));
      end
      8'h02: begin
        exp_q.push_back(w(8'h20, B_IRA_MAR));
        exp_q.push_back(w(8'h21, B_ACC_MBR));
        exp_q.push_back(w(8'h22, B_MEM_WR));
      end
      8'h03: begin
        exp_q.push_back(w(8'h30, B_IRA_MAR));
        exp_q.push_back(w(8'h31, B_MEM_RD | B_MEM_MBR));
        exp_q.push_back(w(8'h32, B_ALU_ADD | B_ALU_ACC));
      end
      8'h04: begin
        exp_q.push_back(w(8'h40, B_IRA_MAR));
        exp_q.push_back(w(8'h41, B_MEM_RD | B_MEM_MBR));
        exp_q.push_back(w(8'h42, B_ALU_SUB | B_ALU_ACC));
      end
      8'h05: begin
        exp_q.push_back(w(8'h50, 14'h0000));
        if (z) exp_q.push_back(w(8'h51, B_IRA_PC));
      end
      8'h06: exp_q.push_back(w(8'h60, B_IRA_PC));
      8'h07: begin
        for (int i = 0; i < hold; i++) exp_q.push_back(w(8'h70, B_HALT));
      end
      default: ;
    endcase
  endtask

  // IR/zflag carry the chosen value only at their decision word; noise elsewhere.
  task automatic run_seq(input logic [7:0] op, input logic z, input int lim, input string tag);
    logic [7:0] a;
    for (int k = 0; k < exp_q.size() && k < lim; k++) begin
      check_eq($sformatf("%s[%0d]", tag, k), CBR, exp_q[k]);
      a = exp_q[k][31:24];
      IR    = (a == 8'h02) ? op : 8'($urandom);
      zflag = (a == 8'h50) ? z : 1'($urandom);
      @(negedge CLK);
    end
  endtask

  task automatic do_reset(input int n, input string tag);
    RST = 1'b1;
    for (int i = 0; i < n; i++) begin
      IR    = 8'($urandom);
      zflag = 1'($urandom);
      @(negedge CLK);
      check_eq($sformatf("%s_rst%0d", tag, i), CBR, 32'h0000_0001);
    end
    RST = 1'b0;
  endtask

  initial begin
    logic [7:0] op;
    logic       z;
    int         r;
    checks   = 0;
    failures = 0;
    RST   = 1'b1;
    IR    = 8'h00;
    zflag = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check_eq("reset", CBR, 32'h0000_0001);
    RST = 1'b0;

    exp_q = '{32'h0000_0001, 32'h0100_000E, 32'h0200_0010,
              32'h1000_0020, 32'h1100_0006, 32'h1200_0040};
    run_seq(8'h01, 1'b0, 100, "load_lit");
    check_eq("load_end", CBR, 32'h0000_0001);

    build(8'h02, 1'b0, 0); run_seq(8'h02, 1'b0, 100, "store");
    check_eq("store_last", exp_q[exp_q.size()-1], 32'h2200_0100);
    build(8'h03, 1'b0, 0); run_seq(8'h03, 1'b0, 100, "add");
    build(8'h04, 1'b0, 0); run_seq(8'h04, 1'b0, 100, "sub");
    build(8'h05, 1'b1, 0); run_seq(8'h05, 1'b1, 100, "jz1");
    build(8'h05, 1'b0, 0); run_seq(8'h05, 1'b0, 100, "jz0");
    build(8'h06, 1'b0, 0); run_seq(8'h06, 1'b0, 100, "jmp");
    build(8'h00, 1'b0, 0); run_seq(8'h00, 1'b0, 100, "nop00");
    build(8'hFF, 1'b0, 0); run_seq(8'hFF, 1'b0, 100, "nopff");
    check_eq("after_nop", CBR, 32'h0000_0001);

    build(8'h07, 1'b0, 22); run_seq(8'h07, 1'b0, 100, "halt");
    check_eq("halt_hold", CBR, 32'h7000_2000);
    do_reset(2, "halt");

    build(8'h01, 1'b0, 0); run_seq(8'h01, 1'b0, 4, "abort");
    do_reset(1, "abort");

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      op = (r < 7) ? 8'(r + 1) : 8'($urandom);
      z  = 1'($urandom);
      build(op, z, $urandom_range(20, 28));
      if (op == 8'h07) begin
        run_seq(op, z, 100, $sformatf("rnd%0d_op%02h", n, op));
        check_eq($sformatf("rnd%0d_halt", n), CBR, 32'h7000_2000);
        do_reset($urandom_range(1, 3), $sformatf("rnd%0d", n));
      end else if ($urandom_range(0, 7) == 0) begin
        run_seq(op, z, $urandom_range(1, 5), $sformatf("rnd%0d_op%02h", n, op));
        do_reset(1, $sformatf("rnd%0d", n));
      end else begin
        run_seq(op, z, 100, $sformatf("rnd%0d_op%02h", n, op));
      end
    end
    check_eq("final", CBR, 32'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
